// File: rtl/alu_issue_if.sv
// Handshake and data bundle between decode, register file, this issue stage and the ALU.
// The issue stage uses the slave view; the upstream/downstream environment uses the master view.
interface alu_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [4:0]  rf_a_addr;
   logic [4:0]  rf_b_addr;
   logic [63:0] rf_a_data;
   logic [63:0] rf_b_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [3:0]  alu_op;
   logic [4:0]  wb_addr;
   logic        wb_en;
   logic        rc;
   logic        illegal;

   modport slave (
      input  in_valid, instr, rf_a_data, rf_b_data, flush, out_ready,
      output in_ready, rf_a_addr, rf_b_addr, out_valid,
             alu_a, alu_b, alu_op, wb_addr, wb_en, rc, illegal
   );

   modport master (
      output in_valid, instr, rf_a_data, rf_b_data, flush, out_ready,
      input  in_ready, rf_a_addr, rf_b_addr, out_valid,
             alu_a, alu_b, alu_op, wb_addr, wb_en, rc, illegal
   );
endinterface

// File: rtl/alu_issue.sv
// nPower issue stage: decodes an instruction into ALU op/operands and holds them
// in the ID/EX register behind a valid/ready handshake with flush.
module alu_issue (
   input  logic   clk,
   input  logic   rst,
   alu_issue_if.slave bus
);

   logic [5:0]  po;
   logic [4:0]  rt;
   logic [4:0]  ra;
   logic [4:0]  rb;
   logic [9:0]  xo10;
   logic [8:0]  xo9;
   logic        rc_bit;
   logic [15:0] imm;

   assign po     = bus.instr[31:26];
   assign rt     = bus.instr[25:21];
   assign ra     = bus.instr[20:16];
   assign rb     = bus.instr[15:11];
   assign xo10   = bus.instr[10:1];
   assign xo9    = bus.instr[9:1];
   assign rc_bit = bus.instr[0];
   assign imm    = bus.instr[15:0];

   logic [63:0] dec_a;
   logic [63:0] dec_b;
   logic [3:0]  dec_op;
   logic [4:0]  dec_wb;
   logic        dec_rc;
   logic        dec_ill;
   logic        use_rs;

   // Logical ops read RS through port A; the RT/RS field doubles as their source.
   always_comb begin
      dec_a   = '0;
      dec_b   = '0;
      dec_op  = 4'b0000;
      dec_wb  = '0;
      dec_rc  = 1'b0;
      dec_ill = 1'b1;
      use_rs  = 1'b0;
      if (po == 6'd31) begin
         if (xo9 == 9'd266) begin
            dec_a   = bus.rf_a_data;
            dec_b   = bus.rf_b_data;
            dec_op  = 4'b0010;
            dec_wb  = rt;
            dec_rc  = rc_bit;
            dec_ill = 1'b0;
         end else if (xo9 == 9'd40) begin
            // subf computes RB - RA, so RB feeds A and RA gets inverted on B
            dec_a   = bus.rf_b_data;
            dec_b   = bus.rf_a_data;
            dec_op  = 4'b0110;
            dec_wb  = rt;
            dec_rc  = rc_bit;
            dec_ill = 1'b0;
         end else if (xo10 == 10'd28 || xo10 == 10'd444 || xo10 == 10'd124) begin
            use_rs  = 1'b1;
            dec_a   = bus.rf_a_data;
            dec_b   = bus.rf_b_data;
            dec_wb  = ra;
            dec_rc  = rc_bit;
            dec_ill = 1'b0;
            if (xo10 == 10'd444)
               dec_op = 4'b0001;
            else if (xo10 == 10'd124)
               dec_op = 4'b1100;
            else
               dec_op = 4'b0000;
         end
      end else if (po == 6'd14) begin
         dec_a   = (ra == 5'd0) ? 64'd0 : bus.rf_a_data;
         dec_b   = {{48{imm[15]}}, imm};
         dec_op  = 4'b0010;
         dec_wb  = rt;
         dec_ill = 1'b0;
      end else if (po == 6'd28 || po == 6'd24) begin
         use_rs  = 1'b1;
         dec_a   = bus.rf_a_data;
         dec_b   = {48'd0, imm};
         dec_op  = (po == 6'd24) ? 4'b0001 : 4'b0000;
         dec_wb  = ra;
         dec_rc  = (po == 6'd28);
         dec_ill = 1'b0;
      end
   end

   assign bus.rf_a_addr = use_rs ? rt : ra;
   assign bus.rf_b_addr = rb;

   logic accept;
   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.alu_a     <= '0;
         bus.alu_b     <= '0;
         bus.alu_op    <= '0;
         bus.wb_addr   <= '0;
         bus.wb_en     <= 1'b0;
         bus.rc        <= 1'b0;
         bus.illegal   <= 1'b0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.alu_a     <= dec_a;
         bus.alu_b     <= dec_b;
         bus.alu_op    <= dec_op;
         bus.wb_addr   <= dec_wb;
         bus.wb_en     <= !dec_ill;
         bus.rc        <= dec_rc;
         bus.illegal   <= dec_ill;
      end else if (bus.out_valid && bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: reset, decode table, drain, stall/flush and reset-in-stall.
module tb_alu_issue;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   alu_issue_if bus ();

   alu_issue dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // {out_valid, alu_a, alu_b, alu_op, wb_addr, wb_en, rc, illegal}
   logic [140:0] obs;
   assign obs = {bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_op,
                 bus.wb_addr, bus.wb_en, bus.rc, bus.illegal};

   typedef struct {
      string        name;
      logic [31:0]  instr;
      logic [63:0]  a_data;
      logic [63:0]  b_data;
      logic [4:0]   ra_addr;
      logic [4:0]   rb_addr;
      logic [140:0] exp;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins,
                        input logic [63:0] ad, input logic [63:0] bd);
      bus.in_valid  = v;
      bus.instr     = ins;
      bus.rf_a_data = ad;
      bus.rf_b_data = bd;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h7C642A14, 64'd5, 64'd7);
      tick();
      tick();
      checks++;
      if (obs !== 141'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h want=0", obs);
      end
      rst = 1'b0;
      drive(1'b0, 32'h0, 64'd0, 64'd0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
      end
      tick();
   endtask

   task automatic test_decode();
      vec_t v[10];
      v[0] = '{"add",   32'h7C642A14, 64'd5,    64'd7,  5'd4, 5'd5,
               {1'b1, 64'd5, 64'd7, 4'b0010, 5'd3, 1'b1, 1'b0, 1'b0}};
      v[1] = '{"subf",  32'h7C642850, 64'd10,   64'd3,  5'd4, 5'd5,
               {1'b1, 64'd3, 64'd10, 4'b0110, 5'd3, 1'b1, 1'b0, 1'b0}};
      v[2] = '{"addi_r0", 32'h3820FFFF, 64'h1234, 64'd9, 5'd0, 5'd31,
               {1'b1, 64'd0, 64'hFFFFFFFFFFFFFFFF, 4'b0010, 5'd1, 1'b1, 1'b0, 1'b0}};
      v[3] = '{"addi",  32'h38430005, 64'd100,  64'd0,  5'd3, 5'd0,
               {1'b1, 64'd100, 64'd5, 4'b0010, 5'd2, 1'b1, 1'b0, 1'b0}};
      v[4] = '{"and_rc", 32'h7CC53839, 64'hF0F0, 64'hFF00, 5'd6, 5'd7,
               {1'b1, 64'hF0F0, 64'hFF00, 4'b0000, 5'd5, 1'b1, 1'b1, 1'b0}};
      v[5] = '{"or",    32'h7CC53B78, 64'd1,    64'd2,  5'd6, 5'd7,
               {1'b1, 64'd1, 64'd2, 4'b0001, 5'd5, 1'b1, 1'b0, 1'b0}};
      v[6] = '{"nor",   32'h7CC538F8, 64'd3,    64'd4,  5'd6, 5'd7,
               {1'b1, 64'd3, 64'd4, 4'b1100, 5'd5, 1'b1, 1'b0, 1'b0}};
      v[7] = '{"andi",  32'h70C58001, 64'hABCD, 64'd0,  5'd6, 5'd16,
               {1'b1, 64'hABCD, 64'h8001, 4'b0000, 5'd5, 1'b1, 1'b1, 1'b0}};
      v[8] = '{"ori",   32'h60C500F0, 64'd77,   64'd0,  5'd6, 5'd0,
               {1'b1, 64'd77, 64'hF0, 4'b0001, 5'd5, 1'b1, 1'b0, 1'b0}};
      v[9] = '{"illegal", 32'h00000000, 64'd55, 64'd66, 5'd0, 5'd0,
               {1'b1, 64'd0, 64'd0, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b1}};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, v[i].instr, v[i].a_data, v[i].b_data);
         #1;
         checks++;
         if ({bus.rf_a_addr, bus.rf_b_addr} !== {v[i].ra_addr, v[i].rb_addr}) begin
            errors++;
            $display("FAIL %s_addr got=%0d/%0d want=%0d/%0d", v[i].name,
                     bus.rf_a_addr, bus.rf_b_addr, v[i].ra_addr, v[i].rb_addr);
         end
         tick();
         checks++;
         if (obs !== v[i].exp) begin
            errors++;
            $display("FAIL %s_out got=%h want=%h", v[i].name, obs, v[i].exp);
         end
      end
   endtask

   task automatic test_rc_oe();
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h7C642E15, 64'd8, 64'd9);
      tick();
      checks++;
      if (obs !== {1'b1, 64'd8, 64'd9, 4'b0010, 5'd3, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL add_oe_rc got=%h", obs);
      end
   endtask

   task automatic test_drain();
      bus.out_ready = 1'b1;
      drive(1'b0, 32'h0, 64'd0, 64'd0);
      tick();
      checks++;
      if ({bus.out_valid, bus.alu_a, bus.alu_b} !== {1'b0, 64'd8, 64'd9}) begin
         errors++;
         $display("FAIL drain got=%b/%0d/%0d want=0/8/9", bus.out_valid, bus.alu_a, bus.alu_b);
      end
   endtask

   task automatic test_back_to_back();
      logic [140:0] first;
      logic [140:0] second;
      first  = {1'b1, 64'd5, 64'd7, 4'b0010, 5'd3, 1'b1, 1'b0, 1'b0};
      second = {1'b1, 64'd3, 64'd10, 4'b0110, 5'd3, 1'b1, 1'b0, 1'b0};
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h7C642A14, 64'd5, 64'd7);
      tick();
      drive(1'b1, 32'h7C642850, 64'd10, 64'd3);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_in_ready got=%b want=0", bus.in_ready);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (obs !== first) begin
            errors++;
            $display("FAIL stall_hold%0d got=%h want=%h", c, obs, first);
         end
      end
      bus.out_ready = 1'b1;
      tick();
      checks++;
      if (obs !== second) begin
         errors++;
         $display("FAIL no_bubble got=%h want=%h", obs, second);
      end
      bus.out_ready = 1'b0;
      drive(1'b0, 32'h0, 64'd0, 64'd0);
      tick();
      drive(1'b1, 32'h38430005, 64'd1, 64'd0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush got=%b want=0", bus.out_valid);
      end
      drive(1'b0, 32'h0, 64'd0, 64'd0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_dropped got=%b want=0", bus.out_valid);
      end
   endtask

   task automatic test_reset_stall();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h7C642A14, 64'd5, 64'd7);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_load got=%b want=1", bus.out_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b0, 32'h0, 64'd0, 64'd0);
      checks++;
      if (obs !== 141'd0) begin
         errors++;
         $display("FAIL reset_mid_stall got=%h want=0", obs);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_rc_oe();
      test_drain();
      test_back_to_back();
      test_reset_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage feeding the 64-bit ALU in the nPower execute stage: decodes a 32-bit nPower instruction into the ALU's 4-bit operation code and operand values, and registers them in the ID/EX pipeline register. It drives register-file read addresses, selects register or immediate operands, and emits the writeback destination and record (Rc) flag. A valid/ready handshake on both sides provides stall, and a flush input squashes the held instruction.

## Interface
- No parameters. Data width is fixed at 64, register index width at 5.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instr/rf data valid from decode
- in_ready  out  1  stage can accept
- instr  in  32  nPower instruction (bit 31 = MSB = PowerPC bit 0)
- rf_a_addr  out  5  read port A index (combinational from instr)
- rf_b_addr  out  5  read port B index (combinational from instr)
- rf_a_data, rf_b_data  in  64  read data for the two ports, same cycle
- flush  in  1  squash held and incoming instruction
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  execute stage consumes
- alu_a, alu_b  out  64  ALU operands
- alu_op  out  4  {invert A, invert B and carry-in, op[1:0]}; op 00 AND, 01 OR, 10 ADD, 11 SLT
- wb_addr  out  5  destination register
- wb_en  out  1  writeback enable
- rc  out  1  record form: update CR0
- illegal  out  1  unsupported instruction

## Operation
- Fields: PO = instr[31:26], RT/RS = [25:21], RA = [20:16], RB = [15:11], XO10 = [10:1], XO9 = [9:1] (OE = instr[10] ignored), Rc = instr[0], SI/UI = [15:0].
- rf_b_addr = RB always. rf_a_addr = RS for logical ops (and, or, nor, andi., ori), RA otherwise. Unsupported instructions use RA.
- Decode (XO-form is checked before X-form):
  - add: PO 31, XO9 266. A = RA, B = RB, op 0010, wb RT, rc = Rc.
  - subf: PO 31, XO9 40. A = RB data, B = RA data, op 0110, wb RT, rc = Rc. Operands are swapped because subf computes RB − RA.
  - and: PO 31, XO10 28. A = RS, B = RB, op 0000, wb RA, rc = Rc.
  - or: PO 31, XO10 444. Same as and, but op 0001.
  - nor: PO 31, XO10 124. Same as and, but op 1100.
  - addi: PO 14. A = 0 if RA == 0, else RA data. B = sign-extended SI, op 0010, wb RT, rc = 0.
  - andi.: PO 28. A = RS, B = zero-extended UI, op 0000, wb RA, rc = 1.
  - ori: PO 24. Same as andi., but op 0001 and rc = 0.
  - Anything else: illegal = 1, wb_en = 0, rc = 0, alu_op = 0000, alu_a = alu_b = 0.
- wb_en = 1 for every legal instruction.

## Timing
- Single register stage: latency is 1 cycle from the accept edge to out_valid.
- in_ready = !out_valid || out_ready (combinational). An instruction is accepted on a rising edge when in_valid && in_ready && !flush.
- On accept, all output registers load and out_valid becomes 1.
- When out_valid && out_ready && no accept, out_valid becomes 0. The data registers hold their values.
- While out_valid && !out_ready: all outputs hold stable and in_ready = 0.
- Simultaneous consume and accept: the new instruction replaces the old one with no bubble, and out_valid stays 1.
- flush has priority: next cycle out_valid = 0 and any accept in that cycle is dropped. Data registers may hold stale values.
- rst has priority over flush and over accept. Next cycle every output register reads 0: out_valid, alu_a, alu_b, alu_op, wb_addr, wb_en, rc, illegal.
- Reset mid-stall discards the held instruction.
- rf_a_data and rf_b_data are sampled only at the accept edge. No hazard checking or forwarding is done here.

## Test plan
- Reset: assert rst for 2 cycles with in_valid = 1 and instr = 0x7C642A14 -> all outputs 0 and out_valid = 0. in_ready = 1 after release.
- add r3,r4,r5: instr 0x7C642A14, rf_a_data 5, rf_b_data 7, out_ready = 1 -> rf_a_addr 4, rf_b_addr 5. Next cycle: alu_a 5, alu_b 7, alu_op 0010, wb_addr 3, wb_en 1, rc 0.
- subf r3,r4,r5: instr 0x7C642850, rf_a_data 10, rf_b_data 3 -> alu_a 3, alu_b 10, alu_op 0110, wb_addr 3.
- addi r1,r0,-1: instr 0x3820FFFF, rf_a_data 0x1234 -> alu_a 0, alu_b 0xFFFFFFFFFFFFFFFF, alu_op 0010, wb_addr 1.
- Stall and flush: hold out_ready = 0 with two back-to-back instructions -> the first stays stable and in_ready = 0. Raise out_ready -> the second follows with no bubble. Assert flush while the second is held -> out_valid = 0 next cycle.
- Illegal: instr 0x00000000 -> out_valid 1, illegal 1, wb_en 0, alu_op 0000, alu_a = alu_b = 0.
